// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: scans a shadowed bank of hex digits onto common-anode seven-segment pins.
// Define SEG_LEADING_ZERO_BLANK_EN to additionally blank leading zero digits (digit 0 always shown).
module seven_seg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);
    localparam int KW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0]         p_q, p_d;
    logic [KW-1:0]         k_q, k_d;
    logic [4*DIGITS-1:0]   dig_q, dig_d;
    logic [DIGITS-1:0]     blk_q, blk_d;
    logic [6:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  tick_q, tick_d;
    logic                  last_p, last_k, dark;
    logic [DIGITS-1:0]     blank_eff;
    logic [3:0]            nib;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b0000001;
            4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;
            4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;
            4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;
            4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0000100;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b1100000;
            4'hC: glyph = 7'b0110001;
            4'hD: glyph = 7'b1000010;
            4'hE: glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic zero_run;
    always_comb begin
        zero_run  = 1'b1;
        blank_eff = blk_q;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run & (dig_q[4*i +: 4] == 4'd0);
            blank_eff[i] = blk_q[i] | zero_run;
        end
    end
`else
    always_comb blank_eff = blk_q;
`endif

    always_comb begin
        last_p = p_q == PW'(SCAN_DIV - 1);
        last_k = k_q == KW'(DIGITS - 1);
        p_d    = last_p ? '0 : p_q + 1'b1;
        k_d    = last_p ? (last_k ? '0 : k_q + 1'b1) : k_q;
        dig_d  = load ? digits_in : dig_q;
        blk_d  = load ? blank_in : blk_q;
        nib    = dig_q[{k_q, 2'b00} +: 4];
        dark   = last_p || blank_eff[k_q];
        seg_d  = dark ? 7'b1111111 : glyph(nib);
        an_d   = '1;
        if (!dark) an_d[k_q] = 1'b0;
        tick_d = last_p && last_k;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q    <= '0;
            k_q    <= '0;
            dig_q  <= '0;
            blk_q  <= '1;
            seg_q  <= 7'b1111111;
            an_q   <= '1;
            tick_q <= 1'b0;
        end else begin
            p_q    <= p_d;
            k_q    <= k_d;
            dig_q  <= dig_d;
            blk_q  <= blk_d;
            seg_q  <= seg_d;
            an_q   <= an_d;
            tick_q <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: scoreboard bench; the driver predicts each cycle's outputs, a monitor compares.
module tb_seven_seg_scan_driver;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  blank_in = '0;
    logic        load = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    int mp = 0, mk = 0;
    logic [15:0] msh = '0;
    logic [3:0]  mbl = '1;
    logic [11:0] expq[$];
    logic [6:0]  gl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    seven_seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .blank_in(blank_in),
        .load(load), .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got tick/an/seg=%b_%b_%b exp %b_%b_%b", name, $time,
                     got[11], got[10:7], got[6:0], exp[11], exp[10:7], exp[6:0]);
        end
    endtask

    // Called at a negedge: drive inputs, predict the post-edge outputs, return at the next negedge.
    task automatic cyc(input logic ld, input logic [15:0] d, input logic [3:0] b);
        logic [3:0] blk;
        logic       zr;
        logic [6:0] es;
        logic [3:0] ea;
        load = ld; digits_in = d; blank_in = b;
        @(posedge clk);
        blk = mbl;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        zr = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            zr = zr & (msh[4*i +: 4] == 4'd0);
            blk[i] = blk[i] | zr;
        end
`else
        zr = 1'b0;
`endif
        es = 7'b1111111;
        ea = 4'b1111;
        if (!(mp == 3 || blk[mk])) begin
            es = gl[msh[4*mk +: 4]];
            ea[mk] = 1'b0;
        end
        expq.push_back({(mp == 3 && mk == 3), ea, es});
        if (ld) begin msh = d; mbl = b; end
        if (mp == 3) begin mp = 0; mk = (mk + 1) % 4; end else mp++;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 4'h0);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) check("scan", {frame_tick, an, seg}, expq.pop_front());
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #3 rst_n = 1'b0;
        #1 check("reset_async", {frame_tick, an, seg}, {1'b0, 4'b1111, 7'b1111111});
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        run(20);
        cyc(1'b1, 16'h1234, 4'b0000);
        run(32);
        cyc(1'b1, 16'hFEDC, 4'b0000);
        run(16);
        cyc(1'b1, 16'hBA98, 4'b0000);
        run(16);
        cyc(1'b1, 16'h1234, 4'b0100);
        run(16);
        cyc(1'b1, 16'h0050, 4'b0000);
        run(16);
        for (int i = 0; i < 16 && !(mp == 3 && mk == 1); i++) run(1);
        check("align_k1_to_k2", {4'(mp), 4'(mk), 4'd0}, {4'd3, 4'd1, 4'd0});
        cyc(1'b1, 16'h1111, 4'b0000);
        run(16);
        for (int i = 0; i < 4 && !(mp == 2 && mk == 2); i++) run(1);
        #1 rst_n = 1'b0;
        #1 check("reset_midscan", {frame_tick, an, seg}, {1'b0, 4'b1111, 7'b1111111});
        mp = 0; mk = 0; msh = '0; mbl = '1;
        @(negedge clk);
        rst_n = 1'b1;
        run(20);
        #2;
        check("queue_drained", {11'd0, expq.size() != 0}, 12'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
